// File: rtl/adpll_pkg.sv
// ============================================================================
// Module  : adpll_pkg
// Brief   : Shared ADPLL types and constants (phase detector / loop filter).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pd_state_t;

  // Sign bit of the phase error: feedback lagging is positive (DCO must speed up).
  localparam logic c_sign_fb_lag  = 1'b0;
  localparam logic c_sign_fb_lead = 1'b1;

  function automatic int err_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// Module  : edge_sync
// Brief   : Multi-flop synchronizer with registered one-cycle rising-edge pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_primed;
  logic                   r_low_seen;
  logic                   r_rise;

  // An edge only counts once the input has really been sampled low after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_hist     <= 1'b0;
      r_primed   <= 1'b0;
      r_low_seen <= 1'b0;
      r_rise     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist   <= r_sync[SYNC_STAGES-1];
      r_primed <= 1'b1;
      if (r_primed && !r_sync[0]) begin
        r_low_seen <= 1'b1;
      end
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_hist & r_low_seen;
    end
  end

  assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/phase_error_detector.sv
// ============================================================================
// Module  : phase_error_detector
// Brief   : Counting phase detector: signed, saturated ref/fb edge separation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_error_detector
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 16,
  parameter int LOCK_THRESH = 1
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_i,
  input  logic                   ref_clk_i,
  input  logic                   fb_clk_i,
  output logic [ERROR_WIDTH-1:0] error_o,
  output logic                   error_valid_o,
  output logic                   lock_o
);

  localparam int                     c_cnt_w       = ERROR_WIDTH - 1;
  localparam logic [c_cnt_w-1:0]     c_cnt_max     = c_cnt_w'(err_max(ERROR_WIDTH));
  localparam logic [c_cnt_w-1:0]     c_cnt_one     = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]     c_lock_thresh = c_cnt_w'(LOCK_THRESH);
  localparam int                     c_lock_w      = $clog2(LOCK_COUNT + 1);
  localparam logic [c_lock_w-1:0]    c_lock_full   = c_lock_w'(LOCK_COUNT);

  logic                   w_ref_rise;
  logic                   w_fb_rise;
  pd_state_t              r_state;
  pd_state_t              w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     w_cnt_nxt;
  logic [c_cnt_w-1:0]     w_cnt_inc;
  logic                   w_emit;
  logic [c_cnt_w-1:0]     w_emit_mag;
  logic                   w_emit_sign;
  logic [ERROR_WIDTH-1:0] w_emit_val;
  logic                   w_in_thresh;
  logic [c_lock_w-1:0]    r_lock_cnt;
  logic [c_lock_w-1:0]    w_lock_inc;
  logic [ERROR_WIDTH-1:0] r_error;
  logic                   r_valid;
  logic                   r_lock;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk     (gen_clk_i),
    .rst     (reset_i),
    .i_async (ref_clk_i),
    .o_rise  (w_ref_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk     (gen_clk_i),
    .rst     (reset_i),
    .i_async (fb_clk_i),
    .o_rise  (w_fb_rise)
  );

  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_emit_mag  = '0;
    w_emit_sign = c_sign_fb_lag;
    case (r_state)
      IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_emit = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt = REF_LEAD;
          w_cnt_nxt   = c_cnt_one;
        end else if (w_fb_rise) begin
          w_state_nxt = FB_LEAD;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      REF_LEAD: begin
        if (w_fb_rise) begin
          w_emit     = 1'b1;
          w_emit_mag = r_cnt;
          if (w_ref_rise) begin
            w_cnt_nxt = c_cnt_one;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else if (w_ref_rise) begin
          w_emit     = 1'b1;
          w_emit_mag = c_cnt_max;
          w_cnt_nxt  = c_cnt_one;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      FB_LEAD: begin
        w_emit_sign = c_sign_fb_lead;
        if (w_ref_rise) begin
          w_emit     = 1'b1;
          w_emit_mag = r_cnt;
          if (w_fb_rise) begin
            w_cnt_nxt = c_cnt_one;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else if (w_fb_rise) begin
          w_emit     = 1'b1;
          w_emit_mag = c_cnt_max;
          w_cnt_nxt  = c_cnt_one;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Magnitude never exceeds ERR_MAX, so the most negative code cannot appear.
  assign w_emit_val  = (w_emit_sign == c_sign_fb_lead) ? ERROR_WIDTH'(0) - {1'b0, w_emit_mag}
                                                       : {1'b0, w_emit_mag};
  assign w_in_thresh = (w_emit_mag <= c_lock_thresh);
  assign w_lock_inc  = r_lock_cnt + c_lock_w'(1);

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_error    <= '0;
      r_valid    <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_emit;
      if (w_emit) begin
        r_error <= w_emit_val;
        if (!w_in_thresh) begin
          r_lock_cnt <= '0;
          r_lock     <= 1'b0;
        end else if (r_lock_cnt != c_lock_full) begin
          r_lock_cnt <= w_lock_inc;
          r_lock     <= (w_lock_inc == c_lock_full);
        end
      end
    end
  end

  assign error_o       = r_error;
  assign error_valid_o = r_valid;
  assign lock_o        = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_phase_error_detector.sv
// ============================================================================
// Module  : tb_phase_error_detector
// Brief   : Randomized self-checking bench against an edge-timestamp model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_phase_error_detector;

  localparam int EW      = 8;
  localparam int EMAX    = 127;
  localparam int LC      = 16;
  localparam int LT      = 1;
  localparam int MAXLEN  = 400;

  logic          gen_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          ref_clk = 1'b0;
  logic          fb_clk  = 1'b0;
  logic [EW-1:0] error;
  logic          error_valid;
  logic          lock;

  phase_error_detector #(
    .ERROR_WIDTH (EW),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (LC),
    .LOCK_THRESH (LT)
  ) dut (
    .gen_clk_i     (gen_clk),
    .reset_i       (reset),
    .ref_clk_i     (ref_clk),
    .fb_clk_i      (fb_clk),
    .error_o       (error),
    .error_valid_o (error_valid),
    .lock_o        (lock)
  );

  always #5 gen_clk = ~gen_clk;

  typedef struct {
    int val;
    bit lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_open = 0;  // 0 none, 1 ref leading, 2 fb leading
  int   model_t0 = 0;
  int   now = 0;
  int   lock_run = 0;
  bit   prev_ref = 1'b0;
  bit   prev_fb  = 1'b0;
  int   last_val = 0;
  bit   last_lock = 1'b0;
  bit   ref_lvl[MAXLEN];
  bit   fb_lvl[MAXLEN];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int clampv(input int x);
    return (x > EMAX) ? EMAX : x;
  endfunction

  task automatic model_emit(input int v);
    exp_t e;
    if (v >= -LT && v <= LT) lock_run = (lock_run < LC) ? lock_run + 1 : LC;
    else lock_run = 0;
    e.val = v;
    e.lk  = (lock_run == LC);
    exp_q.push_back(e);
  endtask

  // Edge timestamps: measurement opens on the first edge, closes on the other one.
  task automatic model_step(input bit r, input bit f);
    case (model_open)
      0: begin
        if (r && f) model_emit(0);
        else if (r) begin model_open = 1; model_t0 = now; end
        else if (f) begin model_open = 2; model_t0 = now; end
      end
      1: begin
        if (f) begin
          model_emit(clampv(now - model_t0));
          if (r) model_t0 = now; else model_open = 0;
        end else if (r) begin
          model_emit(EMAX);
          model_t0 = now;
        end
      end
      default: begin
        if (r) begin
          model_emit(-clampv(now - model_t0));
          if (f) model_t0 = now; else model_open = 0;
        end else if (f) begin
          model_emit(-EMAX);
          model_t0 = now;
        end
      end
    endcase
  endtask

  task automatic clear_seg();
    for (int i = 0; i < MAXLEN; i++) begin
      ref_lvl[i] = 1'b0;
      fb_lvl[i]  = 1'b0;
    end
  endtask

  task automatic add_pulse(input bit is_ref, input int at, input int hold);
    for (int i = at; i < at + hold; i++) begin
      if (is_ref) ref_lvl[i] = 1'b1;
      else        fb_lvl[i]  = 1'b1;
    end
  endtask

  task automatic run_seg(input int n);
    bit r, f;
    for (int t = 0; t < n; t++) begin
      @(negedge gen_clk);
      ref_clk = ref_lvl[t];
      fb_clk  = fb_lvl[t];
      r = ref_lvl[t] & ~prev_ref;
      f = fb_lvl[t] & ~prev_fb;
      prev_ref = ref_lvl[t];
      prev_fb  = fb_lvl[t];
      model_step(r, f);
      now++;
    end
  endtask

  // d > 0: fb edge d cycles after ref edge.
  task automatic pair(input int d);
    int rt, ft, last;
    clear_seg();
    rt = (d >= 0) ? 4 : 4 - d;
    ft = rt + d;
    add_pulse(1'b1, rt, 3);
    add_pulse(1'b0, ft, 3);
    last = (rt > ft) ? rt : ft;
    run_seg(last + 7);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge gen_clk);
    #2;
    reset = 1'b1;
    model_open = 0;
    lock_run   = 0;
    last_val   = 0;
    last_lock  = 1'b0;
    repeat (cycles) @(negedge gen_clk);
    #2;
    reset = 1'b0;
  endtask

  always @(posedge gen_clk) begin
    #1;
    if (reset) begin
      chk("rst_error", int'($signed(error)), 0);
      chk("rst_valid", int'(error_valid), 0);
      chk("rst_lock", int'(lock), 0);
    end else if (error_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e_cur = exp_q.pop_front();
        chk("error", int'($signed(error)), e_cur.val);
        chk("lock_on_strobe", int'(lock), int'(e_cur.lk));
        last_val  = e_cur.val;
        last_lock = e_cur.lk;
      end
    end else begin
      chk("hold_error", int'($signed(error)), last_val);
      chk("hold_lock", int'(lock), int'(last_lock));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both inputs toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge gen_clk);
      ref_clk = 1'($urandom_range(0, 1));
      fb_clk  = 1'($urandom_range(0, 1));
      @(negedge gen_clk);
    end
    @(negedge gen_clk);
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    repeat (4) @(negedge gen_clk);
    #2;
    reset = 1'b0;
    clear_seg();
    run_seg(8);

    // Directed measurements.
    pair(5);
    pair(-3);
    pair(0);
    pair(150);

    // Cycle slip: two ref edges, then fb two cycles after the second.
    clear_seg();
    add_pulse(1'b1, 4, 3);
    add_pulse(1'b1, 44, 3);
    add_pulse(1'b0, 46, 3);
    run_seg(56);

    // Lock acquisition, then loss on an out-of-threshold sample.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) pair(0);
      else if (i % 4 == 1) pair(1);
      else pair(-1);
    end
    pair(4);

    // Reset in the middle of a ref-leading measurement.
    clear_seg();
    add_pulse(1'b1, 4, 3);
    run_seg(16);
    chk("pending_before_reset", exp_q.size(), 0);
    do_reset(3);
    clear_seg();
    run_seg(6);
    pair(7);

    // Randomized measurements.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)     pair(int'($urandom_range(0, 300)) - 150);
      else if (sel < 4) pair(int'($urandom_range(0, 2)) - 1);
      else              pair(int'($urandom_range(0, 20)) - 10);
    end

    repeat (12) @(negedge gen_clk);
    chk("pending_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
